// File: rtl/md_sched_if.sv
// rtl/md_sched_if.sv - E/D-stage handshake bundle between the pipeline and the mult/div scheduler
interface md_sched_if;
    logic        start_E;
    logic [2:0]  MDOp_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        HILOSel_E;
    logic        md_use_D;
    logic [31:0] HILO_out;
    logic        busy;
    logic        stall_md;

    modport master (
        output start_E, MDOp_E, A_E, B_E, HILOSel_E, md_use_D,
        input  HILO_out, busy, stall_md
    );

    modport slave (
        input  start_E, MDOp_E, A_E, B_E, HILOSel_E, md_use_D,
        output HILO_out, busy, stall_md
    );
endinterface

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle mult/div scheduler owning HI/LO; MD_MADD_EN enables madd (MDOp 111)
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_sched_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_hi_p, r_lo_p;

    logic        w_is_mult, w_is_div, w_is_madd, w_long, w_valid_op;
    logic        w_busy, w_stall;
    logic [31:0] w_hilo;
    logic [63:0] w_prod_s, w_prod_u, w_pend;
    logic [31:0] w_dvs, w_sq, w_sr, w_uq, w_ur;
    logic        w_div_ovf;
`ifdef MD_MADD_EN
    logic [63:0] w_madd;
`endif

    always_comb begin
        w_is_madd = 1'b0;
`ifdef MD_MADD_EN
        w_is_madd = (bus.MDOp_E == OP_MADD);
`endif
        w_is_mult  = (bus.MDOp_E == OP_MULT) || (bus.MDOp_E == OP_MULTU) || w_is_madd;
        w_is_div   = (bus.MDOp_E == OP_DIV) || (bus.MDOp_E == OP_DIVU);
        w_long     = bus.start_E && (w_is_mult || w_is_div);
        w_valid_op = w_long || (bus.start_E && (bus.MDOp_E == OP_MTHI || bus.MDOp_E == OP_MTLO));
    end

    assign w_prod_s = $signed({{32{bus.A_E[31]}}, bus.A_E}) * $signed({{32{bus.B_E[31]}}, bus.B_E});
    assign w_prod_u = {32'b0, bus.A_E} * {32'b0, bus.B_E};
`ifdef MD_MADD_EN
    assign w_madd   = {r_hi, r_lo} + w_prod_s;
`endif

    // Divisor forced to 1 on zero so the divider never sees /0; that result is discarded anyway.
    assign w_dvs     = (bus.B_E == 32'd0) ? 32'd1 : bus.B_E;
    assign w_div_ovf = (bus.A_E == 32'h8000_0000) && (bus.B_E == 32'hFFFF_FFFF);
    assign w_sq      = w_div_ovf ? 32'h8000_0000 : 32'($signed(bus.A_E) / $signed(w_dvs));
    assign w_sr      = w_div_ovf ? 32'd0 : 32'($signed(bus.A_E) % $signed(w_dvs));
    assign w_uq      = bus.A_E / w_dvs;
    assign w_ur      = bus.A_E % w_dvs;

    always_comb begin
        w_pend = {r_hi, r_lo};
        case (bus.MDOp_E)
            OP_MULT:  w_pend = w_prod_s;
            OP_MULTU: w_pend = w_prod_u;
            OP_DIV:   if (bus.B_E != 32'd0) w_pend = {w_sr, w_sq};
            OP_DIVU:  if (bus.B_E != 32'd0) w_pend = {w_ur, w_uq};
`ifdef MD_MADD_EN
            OP_MADD:  w_pend = w_madd;
`endif
            default:  w_pend = {r_hi, r_lo};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_long) w_next = S_RUN;
            S_RUN:   if (r_cnt == 4'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == S_RUN);
        w_stall = bus.md_use_D && (w_busy || w_long);
        w_hilo  = bus.HILOSel_E ? r_lo : r_hi;
    end

    assign bus.busy     = w_busy;
    assign bus.stall_md = w_stall;
    assign bus.HILO_out = w_hilo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= 4'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_hi_p <= 32'd0;
            r_lo_p <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_long) begin
                {r_hi_p, r_lo_p} <= w_pend;
                r_cnt            <= w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (bus.start_E && bus.MDOp_E == OP_MTHI) begin
                r_hi <= bus.A_E;
            end else if (bus.start_E && bus.MDOp_E == OP_MTLO) begin
                r_lo <= bus.A_E;
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_hi <= r_hi_p;
                r_lo <= r_lo_p;
            end
        end
    end

    // The hazard unit holds md ops in D while busy, so none can issue into a running op.
    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!reset)
        !(r_state == S_RUN && w_valid_op));
endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - self-checking bench for md_sched with a cycle-level HI/LO model
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_sched_if bus();
    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic bit is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
        if (op == 3'd7) return 1'b1;
`endif
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Model: committed HI/LO plus one outstanding result with the edge index it lands on.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pend;
    int          cyc = 0;
    int          m_commit;

    always @(posedge clk or negedge rst_n) begin
        longint p, q, r;
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pend = 0;
        end else begin
            cyc++;
            if (m_pend) begin
                if (cyc == m_commit) begin
                    m_hi = m_phi; m_lo = m_plo; m_pend = 0;
                end
            end else if (bus.start_E) begin
                m_phi = m_hi; m_plo = m_lo;
                case (bus.MDOp_E)
                    3'd1: begin p = longint'(int'(bus.A_E)) * longint'(int'(bus.B_E)); {m_phi, m_plo} = p; end
                    3'd2: begin p = longint'({32'b0, bus.A_E}) * longint'({32'b0, bus.B_E}); {m_phi, m_plo} = p; end
                    3'd3: if (bus.B_E != 0) begin
                        q = longint'(int'(bus.A_E)) / longint'(int'(bus.B_E));
                        r = longint'(int'(bus.A_E)) % longint'(int'(bus.B_E));
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                    3'd4: if (bus.B_E != 0) begin
                        m_plo = bus.A_E / bus.B_E; m_phi = bus.A_E % bus.B_E;
                    end
                    3'd5: m_hi = bus.A_E;
                    3'd6: m_lo = bus.A_E;
`ifdef MD_MADD_EN
                    3'd7: begin
                        p = {m_hi, m_lo} + longint'(int'(bus.A_E)) * longint'(int'(bus.B_E));
                        {m_phi, m_plo} = p;
                    end
`endif
                    default: ;
                endcase
                if (is_long(bus.MDOp_E)) begin
                    m_pend = 1;
                    m_commit = cyc + ((bus.MDOp_E == 3'd3 || bus.MDOp_E == 3'd4) ? DC : MC);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = bus.md_use_D & (m_pend | (bus.start_E & is_long(bus.MDOp_E)));
        check("cyc busy", {31'b0, bus.busy}, {31'b0, m_pend});
        check("cyc stall_md", {31'b0, bus.stall_md}, {31'b0, exp_stall});
        check("cyc HILO_out", bus.HILO_out, bus.HILOSel_E ? m_lo : m_hi);
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit use_d, input int exp_busy, input int exp_stall);
        int nb, ns;
        nb = 0; ns = 0;
        @(posedge clk); #1;
        bus.start_E = 1; bus.MDOp_E = op; bus.A_E = a; bus.B_E = b; bus.md_use_D = use_d;
        @(negedge clk);
        if (bus.stall_md) ns++;
        @(posedge clk); #1;
        bus.start_E = 0; bus.MDOp_E = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.stall_md) ns++;
            if (bus.busy) nb++;
            else break;
        end
        bus.md_use_D = 0;
        check({name, " busy cycles"}, nb, exp_busy);
        check({name, " stall cycles"}, ns, exp_stall);
    endtask

    task automatic check_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
        bus.HILOSel_E = 0; #1;
        check({name, " HI"}, bus.HILO_out, hi);
        bus.HILOSel_E = 1; #1;
        check({name, " LO"}, bus.HILO_out, lo);
        bus.HILOSel_E = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_E = 0; bus.MDOp_E = 0; bus.A_E = 0; bus.B_E = 0;
        bus.HILOSel_E = 0; bus.md_use_D = 0;
        #2;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check_hl("reset", 32'd0, 32'd0);
        #21 rst_n = 1;

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h2, 0, 5, 0);
        check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h2, 0, 5, 0);
        check_hl("multu", 32'h1, 32'hFFFF_FFFE);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'h2, 0, 10, 0);
        check_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'd4, 32'h7, 32'h0, 0, 10, 0);
        check_hl("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("mthi", 3'd5, 32'h1234_5678, 32'h0, 1, 0, 0);
        check_hl("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
        run_op("mult use", 3'd1, 32'h3, 32'h5, 1, 5, 6);
        check_hl("mult use", 32'h0, 32'hF);
        run_op("div use", 3'd3, 32'h7, 32'hFFFF_FFFE, 1, 10, 11);
        check_hl("div use", 32'h1, 32'hFFFF_FFFD);

        @(posedge clk); #1;
        bus.start_E = 1; bus.MDOp_E = 3'd3; bus.A_E = 32'd100; bus.B_E = 32'd7;
        @(posedge clk); #1;
        bus.start_E = 0; bus.MDOp_E = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1 check("rst mid busy", {31'b0, bus.busy}, 32'd0);
        check_hl("rst mid", 32'd0, 32'd0);
        @(negedge clk); #2 rst_n = 1;
        repeat (15) @(negedge clk);
        check("rst after busy", {31'b0, bus.busy}, 32'd0);
        check_hl("rst after", 32'd0, 32'd0);

        run_op("mtlo", 3'd6, 32'h1, 32'h0, 0, 0, 0);
        check_hl("mtlo", 32'h0, 32'h1);
`ifdef MD_MADD_EN
        run_op("madd", 3'd7, 32'h3, 32'h4, 1, 5, 6);
        check_hl("madd", 32'h0, 32'hD);
`else
        run_op("op111 off", 3'd7, 32'h3, 32'h4, 1, 0, 0);
        check_hl("op111 off", 32'h0, 32'h1);
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
Multi-cycle multiply/divide scheduler and HI/LO register owner for the 5-stage MIPS pipeline. It accepts an MDOp issued from the E stage and sequences a fixed-latency mult/div operation through a busy state machine. It commits results to HI/LO and drives the stall request the hazard unit uses to hold any HI/LO-using instruction in D. It also supplies the mfhi/mflo read value to the E stage.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu/madd (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_E  input  1  valid, non-flushed E-stage instruction carrying MDOp_E
MDOp_E  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 madd
A_E  input  32  forwarded rs operand
B_E  input  32  forwarded rt operand
HILOSel_E  input  1  read select: 0 HI, 1 LO
md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo/madd
HILO_out  output  32  HILOSel_E ? LO : HI, combinational from committed registers
busy  output  1  multi-cycle operation in progress
stall_md  output  1  md_use_D & (busy | (start_E & MDOp_E in {001,010,011,100,111}))

Behaviour:
- Reset (reset low, asynchronous): HI=0, LO=0, state=IDLE, counter=0, pending result cleared. busy=0, so stall_md reduces to md_use_D & start-term. Mid-operation reset discards the in-flight result.
- States: IDLE, RUN. The counter is 4 bits.
- IDLE, start_E=1, MDOp 001/010/111 at edge k:
  - Compute the 64-bit product into pending {hi_p,lo_p}. 001 is signed, 010 unsigned. 111 gives {HI,LO} + signed(A*B), modulo 2^64.
  - Load counter=MULT_CYCLES and go to RUN.
- IDLE, start_E=1, MDOp 011/100 at edge k:
  - lo_p = quotient, hi_p = remainder. 011 is signed, truncating toward zero, remainder takes the dividend's sign. 100 is unsigned.
  - Load counter=DIV_CYCLES and go to RUN.
  - If B_E==0: still go busy for DIV_CYCLES, but the pending result equals the current HI/LO, so HI/LO are unchanged.
- IDLE, start_E=1, MDOp 101/110: HI (or LO) = A_E at edge k. Single cycle, busy stays 0.
- MDOp 000, or start_E=0: no effect.
- RUN: busy=1. Counter decrements each edge. At the edge where counter==1, {HI,LO} <= {hi_p,lo_p} and state goes to IDLE.
- Timing: busy is high for exactly N cycles after edge k, and the new HI/LO is visible from cycle k+N+1 onward.
- start_E while in RUN: ignored. This cannot occur given stall_md; verify it with an assertion.
- HILO_out always shows committed values, never pending ones. mf* cannot reach E while busy because of the stall.
- The stall_md start-term covers an op issuing in E in the same cycle that a dependent op sits in D.

Optional Feature:
MD_MADD_EN:
- Defined: MDOp 111 performs madd as above and counts in the stall_md start-term.
- Undefined: 111 is treated as 000 (no state change, no busy, not in the start-term), and the accumulate adder is not synthesised.

Test Plan:
- mult A=FFFFFFFF B=00000002 -> busy 5 cycles; then HI=FFFFFFFF, LO=FFFFFFFE.
- multu A=FFFFFFFF B=00000002 -> HI=00000001, LO=FFFFFFFE.
- div A=FFFFFFF9 (-7) B=2 -> busy 10 cycles; LO=FFFFFFFD, HI=FFFFFFFF. Then divu A=7 B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi A=12345678, then mflo/mfhi read (HILOSel 0) next cycle -> HILO_out=12345678 with busy never asserted.
- md_use_D=1 with start_E mult in the same cycle -> stall_md=1 that cycle and for the following 5 cycles, then 0. With md_use_D=0 -> stall_md=0 throughout.
- Reset pulse low at cycle 3 of a div -> busy=0, HI=LO=0 immediately; no commit after release. With MD_MADD_EN: HI=0, LO=1, then madd 3*4 -> HI=0, LO=0000000D.
